fb_vport_timing: RTL
====================

FB_VPORT_TIMING -- requirements
Module: fb_vport_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0; 0 means HS/VS are active-low.
REQ-006 iCLK  in  1  pixel clock; single clock domain, all logic on rising edge.
REQ-007 iRESETn  in  1  reset; synchronous, active-low.
REQ-008 iST_DATA  in  15  pixel, RGB555 packed {R[14:10],G[9:5],B[4:0]}.
REQ-009 iST_DV  in  1  iST_DATA valid.
REQ-010 iST_START  in  1  qualifies the word as first pixel of a frame.
REQ-011 oST_READY  out  1  word transferred when iST_DV & oST_READY.
REQ-012 oRED, oGRN, oBLU  out  8 each  pixel to DVI encoder.
REQ-013 oHS, oVS, oDE  out  1 each  syncs and data enable to DVI encoder.
REQ-014 oUNDERRUN  out  1  sticky: an active pixel found no valid word.
REQ-015 oERR_CNT  out  16  underrun plus resync events, saturating at 0xFFFF.
REQ-016 iCLR_ERR  in  1  clears oUNDERRUN and oERR_CNT on the next edge.

Function
REQ-017 hcnt SHALL count 0..HT-1 and wrap, where HT = sum of the H_* parameters.
REQ-018 vcnt SHALL increment when hcnt wraps, count 0..VT-1, then wrap.
REQ-019 A position is active iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-020 HS is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC; VS uses the same rule on vcnt; assertion level is set by SYNC_POL.
REQ-021 All video outputs SHALL be registered, 1 cycle after the counter state that produced them.
REQ-022 When DE=0, oRED/oGRN/oBLU SHALL output 0.
REQ-023 Each 5-bit colour SHALL expand to 8 bits by replication {c[4:0],c[4:2]}.
REQ-024 The state machine SHALL have three states: HUNT, ARMED, RUN.
REQ-025 HUNT: oST_READY=1; every word is consumed; DE is still generated with black pixels; a consumed START word is latched into a 15-bit hold register and the state goes to ARMED.
REQ-026 ARMED: oST_READY=0; at (h=0,v=0) the hold register is output as the pixel and the state goes to RUN.
REQ-027 RUN: oST_READY equals active for every active position except (0,0).
REQ-028 RUN, (0,0): oST_READY=1; a START word is output as pixel and the state stays RUN.
REQ-029 RUN, (0,0), DV with START=0: output black, count one error, go to HUNT.
REQ-030 RUN, START word consumed at any position other than (0,0): latch it into the hold register, output black, count one error, go to ARMED.
REQ-031 RUN, active position with iST_DV=0 (underrun): output black, set oUNDERRUN, count one error, stay in RUN with no resync.
REQ-032 oST_READY SHALL depend on registered state only (no combinational path from inputs).
REQ-033 If iCLR_ERR and an error event occur in the same cycle, the clear SHALL win.

Reset
REQ-034 On reset: hcnt=vcnt=0, state=HUNT, hold register=0, oRED/oGRN/oBLU=0, oDE=0, oHS and oVS at the inactive level, oST_READY=0 for one cycle, oUNDERRUN=0, oERR_CNT=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; the first edge after release restarts at (0,0) in HUNT.

Structure
REQ-036 A shared package SHALL hold the state enum, the RGB555 field positions, and the 640x480 default timing constants.
REQ-037 The sub-module vid_timing_gen SHALL contain the counters and HS/VS/active generation; the state machine and datapath stay in the top module.

Verification (parameters 8/2/2/2 x 4/1/1/1: HT=14, VT=7)
REQ-038 Reset, then a continuous stream with START on word 0 -> frame 2 shows pixels 0..31 in raster order; DE is high 8 cycles per line; HS is low 2 cycles; oERR_CNT=0.
REQ-039 Data 0x7C00 -> oRED=0xFF, oGRN=0, oBLU=0; data 0x0421 -> all three colours 0x08.
REQ-040 iST_DV dropped for 3 active pixels -> 3 black pixels, oUNDERRUN=1, oERR_CNT=3, next pixel in sequence.
REQ-041 START injected at pixel 10 -> remainder of frame black, oERR_CNT+1, next frame begins with that word.
REQ-042 Reset pulsed mid-line, then iCLR_ERR asserted together with an underrun -> all outputs at reset values, then oERR_CNT=0.

Source files
------------

// File: rtl/fb_vport_timing_pkg.sv
// Shared definitions for the frame-buffer video port: state encoding,
// RGB555 field positions, 640x480 default timing and colour expansion.
package fb_vport_timing_pkg;

    // Stream synchronisation states.
    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // RGB555 packing: {R[14:10], G[9:5], B[4:0]}.
    localparam int RED_MSB = 14;
    localparam int RED_LSB = 10;
    localparam int GRN_MSB = 9;
    localparam int GRN_LSB = 5;
    localparam int BLU_MSB = 4;
    localparam int BLU_LSB = 0;

    // 640x480 @ 60 Hz timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // 5-bit to 8-bit colour by bit replication, so full scale maps to 0xFF.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/fb_vport_timing_vid_timing_gen.sv
// Raster counters with active-area and sync-window decode. Decoded flags are
// combinational from the counter registers; the caller registers them.
module vid_timing_gen
    import fb_vport_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_active,
    output logic o_first,
    output logic o_hs,
    output logic o_vs
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One extra count of headroom so the sync-end bound stays representable
    // even when the back porch is zero.
    localparam int HW = $clog2(HT + 1);
    localparam int VW = $clog2(VT + 1);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          w_h_wrap;

    assign w_h_wrap = (r_hcnt == H_LAST);

    // Pixel counter wraps every line; line counter steps on each pixel wrap.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= w_h_wrap ? '0 : r_hcnt + HW'(1);
            if (w_h_wrap) begin
                r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
            end
        end
    end

    assign o_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign o_first  = (r_hcnt == '0) && (r_vcnt == '0);
    assign o_hs     = (r_hcnt >= H_SS) && (r_hcnt < H_SE);
    assign o_vs     = (r_vcnt >= V_SS) && (r_vcnt < V_SE);

endmodule

// File: rtl/fb_vport_timing.sv
// Video port: locks an RGB555 pixel stream to the raster using frame-start
// markers, drives registered RGB888/HS/VS/DE, and counts stream errors.
module fb_vport_timing
    import fb_vport_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0
) (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic [14:0] iST_DATA,
    input  logic        iST_DV,
    input  logic        iST_START,
    output logic        oST_READY,
    output logic [7:0]  oRED,
    output logic [7:0]  oGRN,
    output logic [7:0]  oBLU,
    output logic        oHS,
    output logic        oVS,
    output logic        oDE,
    output logic        oUNDERRUN,
    output logic [15:0] oERR_CNT,
    input  logic        iCLR_ERR
);

    // Level driven on HS/VS while the sync window is open.
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic        w_active;
    logic        w_first;
    logic        w_hs_act;
    logic        w_vs_act;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [14:0] r_hold;
    logic [14:0] w_hold_nxt;
    logic [14:0] w_pix;
    logic        w_err;
    logic        w_udr;
    logic        w_ready;
    logic        r_ready_en;

    logic [7:0]  r_red;
    logic [7:0]  r_grn;
    logic [7:0]  r_blu;
    logic        r_hs;
    logic        r_vs;
    logic        r_de;
    logic        r_underrun;
    logic [15:0] r_err_cnt;

    vid_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (iCLK),
        .i_rst_n  (iRESETn),
        .o_active (w_active),
        .o_first  (w_first),
        .o_hs     (w_hs_act),
        .o_vs     (w_vs_act)
    );

    // Ready is decoded from registered state and counters only; r_ready_en
    // holds it low for the first cycle out of reset.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and infers a latch.
        w_ready = 1'b0;
        case (r_state)
            ST_HUNT:  w_ready = 1'b1;
            ST_RUN:   w_ready = w_active;
            default:  w_ready = 1'b0;
        endcase
        w_ready = w_ready & r_ready_en;
    end

    assign oST_READY = w_ready;

    // Stream lock decisions: which pixel to show, next state, error events.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_pix       = '0;
        w_err       = 1'b0;
        w_udr       = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (iST_DV && w_ready && iST_START) begin
                    w_hold_nxt  = iST_DATA;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_first) begin
                    w_pix       = r_hold;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_active) begin
                    if (!iST_DV) begin
                        // Starved: show black but keep lock.
                        w_udr = 1'b1;
                        w_err = 1'b1;
                    end else if (w_first) begin
                        if (iST_START) begin
                            w_pix = iST_DATA;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_HUNT;
                        end
                    end else if (iST_START) begin
                        // Early frame start: keep it for the next raster origin.
                        w_hold_nxt  = iST_DATA;
                        w_err       = 1'b1;
                        w_state_nxt = ST_ARMED;
                    end else begin
                        w_pix = iST_DATA;
                    end
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // State, hold register, registered video outputs and error bookkeeping.
    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!iRESETn) begin
            r_state    <= ST_HUNT;
            r_hold     <= '0;
            r_ready_en <= 1'b0;
            r_red      <= '0;
            r_grn      <= '0;
            r_blu      <= '0;
            r_hs       <= ~SYNC_ON;
            r_vs       <= ~SYNC_ON;
            r_de       <= 1'b0;
            r_underrun <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_ready_en <= 1'b1;
            r_red      <= expand5(w_pix[RED_MSB:RED_LSB]);
            r_grn      <= expand5(w_pix[GRN_MSB:GRN_LSB]);
            r_blu      <= expand5(w_pix[BLU_MSB:BLU_LSB]);
            r_hs       <= w_hs_act ? SYNC_ON : ~SYNC_ON;
            r_vs       <= w_vs_act ? SYNC_ON : ~SYNC_ON;
            r_de       <= w_active;
            if (iCLR_ERR) begin
                r_underrun <= 1'b0;
                r_err_cnt  <= '0;
            end else begin
                if (w_udr) begin
                    r_underrun <= 1'b1;
                end
                if (w_err && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign oRED      = r_red;
    assign oGRN      = r_grn;
    assign oBLU      = r_blu;
    assign oHS       = r_hs;
    assign oVS       = r_vs;
    assign oDE       = r_de;
    assign oUNDERRUN = r_underrun;
    assign oERR_CNT  = r_err_cnt;

endmodule
